// File: rtl/multdiv_sequencer.sv
// Purpose: shift-add multiply / restoring divide sequencer that owns the HI/LO registers.
// Latency: start edge E0, HI/LO written at E(WIDTH+2), done pulses the following cycle; div-by-zero ends at E1.
// Backpressure: stall holds HI/LO-dependent instructions while busy; start/mthi/mtlo are dropped while busy.
module multdiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             mf_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] OP_MULT = 2'd0;
    localparam logic [1:0] OP_DIV  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [1:0]           op_q;
    logic                 sign_a_q;
    logic                 sign_b_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 done_q;

    logic                 is_div;
    logic                 is_signed;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 div_by_zero;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;

    logic [WIDTH:0]       rem_sh;
    logic [WIDTH-1:0]     rem_diff;
    logic                 rem_ge;
    logic [2*WIDTH-1:0]   div_next;

    logic                 neg_prod;
    logic                 neg_quot;
    logic                 neg_rem;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign is_div      = op_q[1];
    assign is_signed   = ~op_q[0];
    assign mag_a       = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    assign mag_b       = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
    assign div_by_zero = is_div && (b_q == '0);

    // Multiply step: acc = {partial product, remaining multiplier bits}
    assign addend   = acc_q[0] ? a_q : '0;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide step: acc = {remainder, quotient}; rem_sh is the remainder after the left shift.
    // Remainder stays below the divisor, so the subtraction never needs the shifted-out bit.
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign rem_diff = rem_sh[WIDTH-1:0] - b_q;
    assign rem_ge   = rem_sh >= {1'b0, b_q};
    assign div_next = {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};

    assign neg_prod = (op_q == OP_MULT) && (sign_a_q ^ sign_b_q);
    assign neg_quot = (op_q == OP_DIV) && (sign_a_q ^ sign_b_q);
    assign neg_rem  = (op_q == OP_DIV) && sign_a_q;
    assign prod_fix = neg_prod ? -acc_q : acc_q;
    assign quot_fix = neg_quot ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_PREP;
            S_PREP:  state_d = div_by_zero ? S_IDLE : S_CALC;
            S_CALC:  if (cnt_q == CNT_LAST) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    // start wins over a same-cycle MTHI/MTLO
                    if (start) begin
                        op_q     <= op;
                        a_q      <= operand_a;
                        b_q      <= operand_b;
                        sign_a_q <= operand_a[WIDTH-1];
                        sign_b_q <= operand_b[WIDTH-1];
                    end else begin
                        if (mthi) hi_q <= wdata;
                        if (mtlo) lo_q <= wdata;
                    end
                end
                S_PREP: begin
                    a_q   <= mag_a;
                    b_q   <= mag_b;
                    acc_q <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                    cnt_q <= '0;
                    if (div_by_zero) done_q <= 1'b1;
                end
                S_CALC: begin
                    acc_q <= is_div ? div_next : mul_next;
                    cnt_q <= cnt_q + CW'(1);
                end
                S_FIX: begin
                    if (is_div) begin
                        lo_q <= quot_fix;
                        hi_q <= rem_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign stall = busy & (start | mthi | mtlo | mf_req);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: directed vectors, corner sequences and a random run against a reference model.
module tb_multdiv_sequencer;

    localparam int W = 32;
    localparam int LAT = W + 2;
    localparam int NVEC = 10;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] wdata;
    logic         mf_req;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         stall;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    multdiv_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wdata     (wdata),
        .mf_req    (mf_req),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .stall     (stall)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: architectural result via wide integer arithmetic
    task automatic model_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: begin
                p = sa * sb;
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            2'd1: begin
                p = {32'b0, a} * {32'b0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            2'd2: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            default: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
        endcase
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (done !== 1'b1 && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output int edges);
        @(negedge clk);
        op = o;
        operand_a = a;
        operand_b = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(edges);
    endtask

    task automatic write_hilo(input logic whi, input logic wlo, input logic [W-1:0] d);
        @(negedge clk);
        mthi = whi;
        mtlo = wlo;
        wdata = d;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
    endtask

    initial begin
        int edges;
        int bad;
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0] = '{2'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{2'd3, 32'd7,          32'd2,         32'd1,         32'd3};
        vecs[3] = '{2'd2, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[5] = '{2'd2, 32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[6] = '{2'd0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'd0};
        vecs[7] = '{2'd3, 32'hFFFF_FFFF,  32'd1,         32'd0,         32'hFFFF_FFFF};
        vecs[8] = '{2'd1, 32'h1234_5678,  32'd0,         32'd0,         32'd0};
        vecs[9] = '{2'd3, 32'd5,          32'd7,         32'd5,         32'd0};

        reset_n = 1'b0;
        start = 1'b0;
        op = 2'd0;
        operand_a = '0;
        operand_b = '0;
        mthi = 1'b0;
        mtlo = 1'b0;
        wdata = '0;
        mf_req = 1'b0;
        #12;
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < NVEC; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, edges);
            chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
            chk($sformatf("vec%0d_latency", i), 64'(edges), 64'(LAT));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
        end

        // Preload then divide by zero: HI/LO untouched, done after the PREP edge
        write_hilo(1'b1, 1'b0, 32'h11);
        write_hilo(1'b0, 1'b1, 32'h22);
        chk("mthi_write", 64'(hi), 64'h11);
        chk("mtlo_write", 64'(lo), 64'h22);
        do_op(2'd2, 32'd5, 32'd0, edges);
        chk("div0_latency", 64'(edges), 64'd1);
        chk("div0_hi", 64'(hi), 64'h11);
        chk("div0_lo", 64'(lo), 64'h22);
        chk("div0_busy", 64'(busy), 64'd0);

        // mf_req: no stall while idle, stall on every busy cycle of a MULT
        @(negedge clk);
        mf_req = 1'b1;
        #1;
        chk("idle_mf_no_stall", 64'(stall), 64'd0);
        op = 2'd0;
        operand_a = 32'd3;
        operand_b = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bad = 0;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            if (stall !== 1'b1 || busy !== 1'b1) bad++;
        end
        chk("mf_stall_while_busy", 64'(bad), 64'd0);
        @(negedge clk);
        chk("mf_done_cycle_done", 64'(done), 64'd1);
        chk("mf_done_cycle_stall", 64'(stall), 64'd0);
        chk("mf_mult_lo", 64'(lo), 64'd15);
        mf_req = 1'b0;

        // start with mthi in the same cycle; mtlo while busy is dropped
        @(negedge clk);
        op = 2'd1;
        operand_a = 32'd3;
        operand_b = 32'd4;
        start = 1'b1;
        mthi = 1'b1;
        wdata = 32'hDEAD;
        @(posedge clk);
        #1;
        start = 1'b0;
        mthi = 1'b0;
        mtlo = 1'b1;
        wdata = 32'hBEEF;
        repeat (3) @(posedge clk);
        #1;
        mtlo = 1'b0;
        wait_done(edges);
        chk("start_mthi_hi", 64'(hi), 64'd0);
        chk("start_mthi_lo", 64'(lo), 64'd12);

        // Asynchronous reset in the middle of CALC
        write_hilo(1'b1, 1'b1, 32'h55);
        @(negedge clk);
        op = 2'd0;
        operand_a = 32'd7;
        operand_b = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("pre_reset_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("midop_reset_busy", 64'(busy), 64'd0);
        chk("midop_reset_hi", 64'(hi), 64'd0);
        chk("midop_reset_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        do_op(2'd0, 32'd7, 32'd9, edges);
        chk("post_reset_latency", 64'(edges), 64'(LAT));
        chk("post_reset_hi", 64'(hi), 64'd0);
        chk("post_reset_lo", 64'(lo), 64'd63);

        // Random operations against the reference model
        m_hi = hi;
        m_lo = lo;
        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'd1;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(0, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            model_op(ro, ra, rb);
            do_op(ro, ra, rb, edges);
            chk($sformatf("rand%0d_hi", i), 64'(hi), 64'(m_hi));
            chk($sformatf("rand%0d_lo", i), 64'(lo), 64'(m_lo));
            chk($sformatf("rand%0d_latency", i), 64'(edges),
                (ro[1] && rb == 0) ? 64'd1 : 64'(LAT));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
